// File: rtl/fir_sched_pkg.sv
// Shared types and helpers for the FIR channel scheduler slice.
package fir_sched_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, OUTPUT} fir_sched_state_t;

    // Channel-id width; a single channel still needs a one-bit id field.
    function automatic int ch_w(input int num_ch);
        return (num_ch > 1) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/fir_channel_scheduler_if.sv
// Channel-side, engine-side and result-side handshakes of the FIR channel scheduler.
interface fir_channel_scheduler_if
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [NUM_CH-1:0]            in_valid;
    logic [NUM_CH-1:0]            in_ready;
    logic [NUM_CH*DATA_WIDTH-1:0] in_i;
    logic [NUM_CH*DATA_WIDTH-1:0] in_q;

    logic                  eng_valid;
    logic                  eng_ready;
    logic [DATA_WIDTH-1:0] eng_i;
    logic [DATA_WIDTH-1:0] eng_q;
    logic [CH_W-1:0]       eng_ch;
    logic                  eng_compute;
    logic                  eng_done;
    logic [DATA_WIDTH-1:0] eng_iout;
    logic [DATA_WIDTH-1:0] eng_qout;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_i;
    logic [DATA_WIDTH-1:0] out_q;
    logic [CH_W-1:0]       out_ch;

    modport master (
        input  in_valid, in_i, in_q, eng_ready, eng_done, eng_iout, eng_qout, out_ready,
        output in_ready, eng_valid, eng_i, eng_q, eng_ch, eng_compute, out_valid, out_i, out_q, out_ch
    );

    modport slave (
        output in_valid, in_i, in_q, eng_ready, eng_done, eng_iout, eng_qout, out_ready,
        input  in_ready, eng_valid, eng_i, eng_q, eng_ch, eng_compute, out_valid, out_i, out_q, out_ch
    );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester after ptr (with wrap) wins, one-hot grant plus index.
module rr_arbiter
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH = 4
)(
    input  logic [NUM_CH-1:0]       req,
    input  logic [ch_w(NUM_CH)-1:0] ptr,
    input  logic                    enable,
    output logic [NUM_CH-1:0]       gnt,
    output logic [ch_w(NUM_CH)-1:0] idx
);
    localparam int CH_W = ch_w(NUM_CH);

    logic [CH_W-1:0] cand;
    logic            found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        // Scan ptr+1 .. ptr+NUM_CH so the last winner has lowest priority.
        for (int k = 1; k <= NUM_CH; k++) begin
            cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (enable && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/fir_channel_scheduler.sv
// Time-shares one complex FIR engine among NUM_CH streams with per-channel decimation.
//  state     | meaning
//  IDLE      | arbitrate, accept one sample into the issue register
//  ISSUE     | offer sample to engine until eng_ready
//  WAIT_DONE | compute running, wait for eng_done
//  OUTPUT    | offer tagged result until out_ready
module fir_channel_scheduler
    import fir_sched_pkg::*;
#(
    parameter int NUM_CH            = 4,
    parameter int DATA_WIDTH        = 32,
    parameter int DECIMATION_FACTOR = 8
)(
    input  logic                     clock,
    input  logic                     reset,
    fir_channel_scheduler_if.master  bus,
    output logic                     busy,
    output logic                     protocol_err
);
    localparam int CH_W = ch_w(NUM_CH);
    localparam int DC_W = (DECIMATION_FACTOR > 1) ? $clog2(DECIMATION_FACTOR) : 1;
    localparam logic [DC_W-1:0] DC_LAST = DC_W'(DECIMATION_FACTOR - 1);

    fir_sched_state_t state, state_nxt;

    logic [CH_W-1:0]       rr_ptr;
    logic [CH_W-1:0]       gnt_idx;
    logic [NUM_CH-1:0]     gnt;
    logic [DC_W-1:0]       dec_cnt [NUM_CH];
    logic [DATA_WIDTH-1:0] in_i_ch [NUM_CH];
    logic [DATA_WIDTH-1:0] in_q_ch [NUM_CH];
    logic [DATA_WIDTH-1:0] iss_i, iss_q, res_i, res_q;
    logic [CH_W-1:0]       iss_ch;
    logic                  iss_compute;
    logic                  accept;
    logic                  compute_now;

    // Grants are suppressed while reset is held so every output reads 0.
    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req    (bus.in_valid),
        .ptr    (rr_ptr),
        .enable (state == IDLE && reset),
        .gnt    (gnt),
        .idx    (gnt_idx)
    );

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_i_ch[c] = bus.in_i[c*DATA_WIDTH +: DATA_WIDTH];
            in_q_ch[c] = bus.in_q[c*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign accept      = |(bus.in_valid & gnt);
    assign compute_now = (dec_cnt[gnt_idx] == DC_LAST);

    always_comb begin
        state_nxt       = state;
        bus.in_ready    = gnt;
        bus.eng_valid   = 1'b0;
        bus.out_valid   = 1'b0;
        bus.eng_i       = iss_i;
        bus.eng_q       = iss_q;
        bus.eng_ch      = iss_ch;
        bus.eng_compute = iss_compute;
        bus.out_i       = res_i;
        bus.out_q       = res_q;
        bus.out_ch      = iss_ch;
        busy            = (state != IDLE);
        case (state)
            IDLE: begin
                if (accept) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.eng_valid = 1'b1;
                if (bus.eng_ready) state_nxt = iss_compute ? WAIT_DONE : IDLE;
            end
            WAIT_DONE: begin
                if (bus.eng_done) state_nxt = OUTPUT;
            end
            OUTPUT: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= IDLE;
            rr_ptr       <= CH_W'(NUM_CH - 1);
            iss_i        <= '0;
            iss_q        <= '0;
            iss_ch       <= '0;
            iss_compute  <= 1'b0;
            res_i        <= '0;
            res_q        <= '0;
            protocol_err <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) dec_cnt[c] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                iss_i            <= in_i_ch[gnt_idx];
                iss_q            <= in_q_ch[gnt_idx];
                iss_ch           <= gnt_idx;
                iss_compute      <= compute_now;
                rr_ptr           <= gnt_idx;
                dec_cnt[gnt_idx] <= compute_now ? '0 : dec_cnt[gnt_idx] + 1'b1;
            end
            if (state == WAIT_DONE && bus.eng_done) begin
                res_i <= bus.eng_iout;
                res_q <= bus.eng_qout;
            end
            if (bus.eng_done && state != WAIT_DONE) protocol_err <= 1'b1;
        end
    end

endmodule
